// File: rtl/sccb_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_arbiter
//
// Shares one SCCB master between two register-access requesters:
//   port 0 - power-up configuration sequencer
//   port 1 - runtime register access (e.g. UART-driven exposure/gain tweaks)
//
// A pending request in IDLE is granted, its payload latched onto the SCCB_*
// outputs, and the master's req/busy handshake is driven.  On completion the
// owner receives a one-cycle done pulse, read data (reads only) and an error
// flag.
//
// Parameters:
//   FAIR        1 = alternate between ports on contention, 0 = port 0 wins
//   TIMEOUT_CYC watchdog limit in s_clk_i cycles (timeout build only)
//
// Build option:
//   SCCB_ARB_TIMEOUT_EN  when defined, a 20-bit watchdog aborts a transaction
//                        that stays in ISSUE/WAIT for TIMEOUT_CYC cycles and
//                        reports it with err_o=1.  When undefined, err_o is
//                        tied low and the arbiter waits for the master
//                        indefinitely.
//
// Ports:
//   s_clk_i            system clock, rising edge
//   rst_i              asynchronous active-high reset
//   reqN_i             request from port N, held until doneN_o
//   wrN_i              1 = write, 0 = read
//   addrN_i[7:0]       OV7670 register address
//   wdataN_i[7:0]      write data
//   gntN_o             port N owns the bus (ISSUE through DONE)
//   doneN_o            one-cycle completion pulse to port N
//   rdata_o[7:0]       last read result, held until the next read completes
//   err_o              completion status, valid with doneN_o (1 = timeout)
//   sccb_req_o         request to the SCCB master
//   sccb_wr_o          latched direction
//   sccb_addr_o[7:0]   latched register address
//   sccb_wdata_o[7:0]  latched write data
//   sccb_busy_i        master is transferring
//   sccb_rdata_i[7:0]  master read result, valid when busy falls
// -----------------------------------------------------------------------------
module sccb_arbiter #(
  parameter bit          FAIR        = 1'b1,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic       s_clk_i,
  input  logic       rst_i,
  // port 0
  input  logic       req0_i,
  input  logic       wr0_i,
  input  logic [7:0] addr0_i,
  input  logic [7:0] wdata0_i,
  // port 1
  input  logic       req1_i,
  input  logic       wr1_i,
  input  logic [7:0] addr1_i,
  input  logic [7:0] wdata1_i,
  // status back to requesters
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic [7:0] rdata_o,
  output logic       err_o,
  // SCCB master side
  output logic       sccb_req_o,
  output logic       sccb_wr_o,
  output logic [7:0] sccb_addr_o,
  output logic [7:0] sccb_wdata_o,
  input  logic       sccb_busy_i,
  input  logic [7:0] sccb_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;   // port that currently owns the bus
  logic       last_q,  last_d;    // port served most recently (fairness)
  logic       wr_q,    wr_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       pick_port;          // port that would win a grant this cycle
  logic       timeout_hit;        // watchdog expired this cycle

  // ---------------------------------------------------------------------------
  // Arbitration: with FAIR and both ports pending, the port not served last
  // wins; in every other case port 0 has priority over port 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (FAIR && req0_i && req1_i) begin
      pick_port = ~last_q;
    end else begin
      pick_port = ~req0_i;
    end
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: cleared while IDLE (so it starts from zero on entry to ISSUE),
  // counts every cycle spent in ISSUE and WAIT.  err_q remembers whether the
  // transaction ended by timeout so err_o can be presented during DONE.
  // ---------------------------------------------------------------------------
  logic [19:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign timeout_hit = (cnt_q == (TIMEOUT_CYC - 20'd1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      cnt_d = 20'd0;
      err_d = 1'b0;
    end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + 20'd1;
      if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 20'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = (state_q == S_DONE) && err_q;
`else
  // No watchdog in this build: the master is trusted to finish, and
  // TIMEOUT_CYC has no effect.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          // Payload is captured here only; later requester changes are ignored.
          owner_d = pick_port;
          wr_d    = pick_port ? wr1_i    : wr0_i;
          addr_d  = pick_port ? addr1_i  : addr0_i;
          wdata_d = pick_port ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (timeout_hit) begin
          state_d = S_DONE;
        end else if (sccb_busy_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (timeout_hit) begin
          state_d = S_DONE;
        end else if (!sccb_busy_i) begin
          // Writes leave the previous read result in place.
          if (!wr_q) begin
            rdata_d = sccb_rdata_i;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.  last_q resets to port 1 so port 0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registered state only, so they are all low in
  // IDLE and therefore low straight out of reset.  sccb_req_o is exactly the
  // ISSUE state: it rises with the grant and drops once busy is seen or the
  // watchdog fires.
  // ---------------------------------------------------------------------------
  assign gnt0_o       = (state_q != S_IDLE) && !owner_q;
  assign gnt1_o       = (state_q != S_IDLE) &&  owner_q;
  assign done0_o      = (state_q == S_DONE) && !owner_q;
  assign done1_o      = (state_q == S_DONE) &&  owner_q;
  assign sccb_req_o   = (state_q == S_ISSUE);
  assign sccb_wr_o    = wr_q;
  assign sccb_addr_o  = addr_q;
  assign sccb_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter.  Two instances share the requester inputs:
// index 0 is FAIR=1, index 1 is FAIR=0.  Each has its own simple SCCB master
// model that raises busy for busy_len cycles one edge after seeing a request.
module tb_sccb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
  logic [7:0] rd_val = 8'h00;

  logic [1:0] gnt0, gnt1, done0, done1, err, sreq, swr, busy;
  logic [7:0] rdata [2];
  logic [7:0] saddr [2];
  logic [7:0] swdata[2];
  int         mcnt  [2];

  int  busy_len = 10;
  bit  hang     = 1'b0;
  int  passed   = 0;
  int  total    = 0;

  always #5 clk = ~clk;

  sccb_arbiter #(.FAIR(1'b1), .TIMEOUT_CYC(20'd100)) dut_fair (
    .s_clk_i(clk), .rst_i(rst),
    .req0_i(req0), .wr0_i(wr0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .wr1_i(wr1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0[0]), .gnt1_o(gnt1[0]), .done0_o(done0[0]), .done1_o(done1[0]),
    .rdata_o(rdata[0]), .err_o(err[0]),
    .sccb_req_o(sreq[0]), .sccb_wr_o(swr[0]), .sccb_addr_o(saddr[0]),
    .sccb_wdata_o(swdata[0]), .sccb_busy_i(busy[0]), .sccb_rdata_i(rd_val)
  );

  sccb_arbiter #(.FAIR(1'b0), .TIMEOUT_CYC(20'd100)) dut_prio (
    .s_clk_i(clk), .rst_i(rst),
    .req0_i(req0), .wr0_i(wr0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .wr1_i(wr1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0[1]), .gnt1_o(gnt1[1]), .done0_o(done0[1]), .done1_o(done1[1]),
    .rdata_o(rdata[1]), .err_o(err[1]),
    .sccb_req_o(sreq[1]), .sccb_wr_o(swr[1]), .sccb_addr_o(saddr[1]),
    .sccb_wdata_o(swdata[1]), .sccb_busy_i(busy[1]), .sccb_rdata_i(rd_val)
  );

  // Master model, reset by the same rst as the arbiters.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] <= 1'b0;
        mcnt[i] <= 0;
      end else if (busy[i]) begin
        if (mcnt[i] == 0) busy[i] <= 1'b0;
        else              mcnt[i] <= mcnt[i] - 1;
      end else if (sreq[i] && !hang) begin
        busy[i] <= 1'b1;
        mcnt[i] <= busy_len - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait for doneN on instance d; n = negedges elapsed, found = seen in bound.
  task automatic wait_done(input int port, input int d, input int bound,
                           output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < bound) begin
      @(negedge clk);
      n++;
      if ((port == 0 && done0[d]) || (port == 1 && done1[d])) found = 1'b1;
    end
  endtask

  int n;
  bit found;
  int ord [2][4];
  int tdone[2][4];
  int cnt [2];
  bit any_done;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_gnt_done_err_req_wr[%0d]", d),
            {24'd0, gnt0[d], gnt1[d], done0[d], done1[d], err[d], sreq[d], swr[d], busy[d]}, 32'd0);
      check($sformatf("rst_rdata[%0d]", d),  {24'd0, rdata[d]},  32'h00);
      check($sformatf("rst_addr[%0d]", d),   {24'd0, saddr[d]},  32'h00);
      check($sformatf("rst_wdata[%0d]", d),  {24'd0, swdata[d]}, 32'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    // ---------------- single write on port 0, busy 10 cycles ----------------
    busy_len = 10;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h12; wdata0 = 8'h80;
    @(negedge clk);                          // grant edge passed
    check("wr_gnt0",  gnt0[0], 1'b1);
    check("wr_req",   sreq[0], 1'b1);
    check("wr_wr",    swr[0],  1'b1);
    check("wr_addr",  {24'd0, saddr[0]},  32'h12);
    check("wr_wdata", {24'd0, swdata[0]}, 32'h80);
    addr0 = 8'h55; wdata0 = 8'h11;           // must be ignored after grant
    @(negedge clk);
    check("wr_busy_rise", busy[0], 1'b1);
    check("wr_req_still", sreq[0], 1'b1);
    @(negedge clk);
    check("wr_req_drop", sreq[0], 1'b0);
    check("wr_addr_held", {24'd0, saddr[0]}, 32'h12);
    wait_done(0, 0, 30, n, found);
    check("wr_done_seen", found, 1'b1);
    check("wr_done_cycles", n + 2, 12);      // grant negedge to done negedge
    check("wr_err", err[0], 1'b0);
    check("wr_gnt_in_done", gnt0[0], 1'b1);
    req0 = 1'b0;
    @(negedge clk);
    check("wr_done_pulse_len", done0[0], 1'b0);
    check("wr_gnt_clear", gnt0[0], 1'b0);
    @(negedge clk);

    // ---------------- read on port 1 ----------------
    busy_len = 3; rd_val = 8'h76;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h0A;
    @(negedge clk);
    check("rd_gnt1", {30'd0, gnt1[0], gnt0[0]}, 32'h2);
    check("rd_wr",   swr[0], 1'b0);
    check("rd_addr", {24'd0, saddr[0]}, 32'h0A);
    wait_done(1, 0, 30, n, found);
    check("rd_done_seen", found, 1'b1);
    check("rd_rdata", {24'd0, rdata[0]}, 32'h76);
    check("rd_done0_quiet", done0[0], 1'b0);
    req1 = 1'b0;
    rd_val = 8'h33;
    @(negedge clk);
    @(negedge clk);
    check("rd_rdata_held", {24'd0, rdata[0]}, 32'h76);

    // A write must not disturb rdata even though the master shows new data.
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h20;
    wait_done(1, 0, 30, n, found);
    check("wr1_done_seen", found, 1'b1);
    check("wr1_rdata_unchanged", {24'd0, rdata[0]}, 32'h76);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // ---------------- contention, both instances ----------------
    busy_len = 1;
    cnt[0] = 0; cnt[1] = 0;
    req0 = 1'b1; wr0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 60 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((done0[d] || done1[d]) && cnt[d] < 4) begin
          ord[d][cnt[d]]   = done1[d] ? 1 : 0;
          tdone[d][cnt[d]] = c;
          cnt[d]++;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_fair_count", cnt[0], 4);
    check("cont_prio_count", cnt[1], 4);
    if (cnt[0] == 4) begin
      check("fair_order", {ord[0][0][7:0], ord[0][1][7:0], ord[0][2][7:0], ord[0][3][7:0]}, 32'h00010001);
      check("fair_first_latency", tdone[0][0], 4);
      check("fair_back_to_back_gap", tdone[0][1] - tdone[0][0], 5);
    end
    if (cnt[1] == 4) begin
      check("prio_order", {ord[1][0][7:0], ord[1][1][7:0], ord[1][2][7:0], ord[1][3][7:0]}, 32'h00000000);
    end
    repeat (4) @(negedge clk);

    // ---------------- reset mid-WAIT ----------------
    busy_len = 10;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);                          // now in WAIT with busy high
    check("mid_busy_high", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", sreq[0], 1'b0);
    check("mid_rst_gnt0", gnt0[0], 1'b0);
    check("mid_rst_done0", done0[0], 1'b0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    any_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done0[0]) any_done = 1'b1;
    end
    check("mid_no_done0", any_done, 1'b0);
    busy_len = 2; rd_val = 8'hA5;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h0B;
    @(negedge clk);
    check("post_rst_gnt", {30'd0, gnt1[0], gnt0[0]}, 32'h2);
    check("post_rst_req", sreq[0], 1'b1);
    wait_done(1, 0, 30, n, found);
    check("post_rst_done_seen", found, 1'b1);
    check("post_rst_rdata", {24'd0, rdata[0]}, 32'hA5);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

`ifdef SCCB_ARB_TIMEOUT_EN
    // ---------------- timeout: master never answers ----------------
    hang = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h02;
    wait_done(0, 0, 200, n, found);
    check("to_done_seen", found, 1'b1);
    check("to_done_cycles", n, 101);         // grant at edge 1, done after edge 101
    check("to_err", err[0], 1'b1);
    check("to_req_dropped", sreq[0], 1'b0);
    check("to_rdata_unchanged", {24'd0, rdata[0]}, 32'hA5);
    req0 = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    check("to_err_pulse_len", err[0], 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
